// File: rtl/serial_adder.sv
// ------------------------------------------------------------------
// serial_adder : multi-cycle DIGIT-per-cycle ripple adder/subtractor
// Revision     : 1.0
// ------------------------------------------------------------------
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_carry;
  logic             msb_carry_in;
  logic [WIDTH-1:0] psum_next;

  always_comb begin
    slice_sum    = '0;
    slice_carry  = carry_q;
    msb_carry_in = carry_q;
    // Ripple through the slice; keep the carry into its top bit for overflow.
    for (int i = 0; i < DIGIT; i++) begin
      msb_carry_in = slice_carry;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ slice_carry;
      slice_carry  = (a_q[i] & b_q[i]) | (slice_carry & (a_q[i] ^ b_q[i]));
    end
    psum_next = psum_q >> DIGIT;
    psum_next[WIDTH-1 -: DIGIT] = slice_sum;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    count_d = count_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        psum_d  = psum_next;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_carry;
        if (count_q == CW'(STEPS - 1)) begin
          sum_d   = psum_next;
          cout_d  = slice_carry;
          ovf_d   = slice_carry ^ msb_carry_in;
          zero_d  = (psum_next == '0);
          state_d = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire
